// File: rtl/syzygy_adc_pkg.sv
// Shared FSM state type and default tuning constants for the SYZYGY ADC
// frame-alignment controller.
package syzygy_adc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRst,
    StSettle,
    StCheck,
    StSlip,
    StLocked,
    StFail
  } state_e;

  localparam logic [7:0]  DefPattern      = 8'hF0;
  localparam int unsigned DefRstCycles    = 8;
  localparam int unsigned DefSettleCycles = 16;
  localparam int unsigned DefMatchCount   = 64;
  localparam int unsigned DefMaxSlips     = 8;

  // Consecutive valid mismatches that break an established lock.
  localparam int unsigned MissLimit = 4;

  // Width of the shared RST/SETTLE cycle counter.
  localparam int unsigned CntW = 16;

  function automatic logic is_busy(input state_e s);
    return s inside {StRst, StSettle, StCheck, StSlip};
  endfunction

endpackage

// File: rtl/syzygy_adc_pattern_checker.sv
// Frame compare plus consecutive-match (training) and consecutive-mismatch
// (lock monitor) counters. Each counter is held at zero while its enable is low.
module syzygy_adc_pattern_checker
  import syzygy_adc_pkg::*;
#(
  parameter int unsigned             FRAME_WIDTH = 8,
  parameter logic [FRAME_WIDTH-1:0]  PATTERN     = FRAME_WIDTH'(DefPattern),
  parameter int unsigned             MATCH_COUNT = DefMatchCount
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   check_en,
  input  logic                   monitor_en,
  input  logic [FRAME_WIDTH-1:0] frame_data,
  input  logic                   frame_valid,
  output logic                   miss,
  output logic                   match_done,
  output logic                   miss_limit
);

  localparam int unsigned MatchW = $clog2(MATCH_COUNT + 1);

  logic              hit;
  logic [MatchW-1:0] match_q;
  logic [1:0]        miss_q;

  assign hit  = frame_valid && (frame_data == PATTERN);
  assign miss = frame_valid && (frame_data != PATTERN);

  // Asserted on the valid match that completes the run, so the FSM can move
  // to LOCKED on the following edge.
  assign match_done = hit && (match_q == MatchW'(MATCH_COUNT - 1));
  assign miss_limit = miss && (miss_q == 2'(MissLimit - 1));

  always_ff @(posedge clk) begin
    if (reset || !check_en || miss) begin
      match_q <= '0;
    end else if (hit) begin
      match_q <= match_q + MatchW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !monitor_en || hit) begin
      miss_q <= '0;
    end else if (miss && (miss_q != 2'(MissLimit - 1))) begin
      miss_q <= miss_q + 2'd1;
    end
  end

endmodule

// File: rtl/syzygy_adc_align_ctrl.sv
// ISERDES frame-alignment controller: reset, settle, check, bitslip until lock or
// failure. Define SYZYGY_ADC_ALIGN_MONITOR_EN to retrain automatically on lock loss.
module syzygy_adc_align_ctrl
  import syzygy_adc_pkg::*;
#(
  parameter int unsigned             FRAME_WIDTH   = 8,
  parameter logic [FRAME_WIDTH-1:0]  PATTERN       = FRAME_WIDTH'(DefPattern),
  parameter int unsigned             RST_CYCLES    = DefRstCycles,
  parameter int unsigned             SETTLE_CYCLES = DefSettleCycles,
  parameter int unsigned             MATCH_COUNT   = DefMatchCount,
  parameter int unsigned             MAX_SLIPS     = DefMaxSlips
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [FRAME_WIDTH-1:0] frame_data,
  input  logic                   frame_valid,
  output logic                   serdes_reset,
  output logic                   bitslip,
  output logic                   busy,
  output logic                   locked,
  output logic                   fail,
  output logic [3:0]             slip_count
);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      slip_d;
  logic            check_en, monitor_en;
  logic            miss, match_done, miss_limit;

  assign check_en = (state_q == StCheck);

`ifdef SYZYGY_ADC_ALIGN_MONITOR_EN
  assign monitor_en = (state_q == StLocked);
`else
  // Lock is sticky: the mismatch counter stays idle and its flag is dropped.
  logic unused_miss_limit;
  assign monitor_en        = 1'b0;
  assign unused_miss_limit = miss_limit;
`endif

  syzygy_adc_pattern_checker #(
    .FRAME_WIDTH (FRAME_WIDTH),
    .PATTERN     (PATTERN),
    .MATCH_COUNT (MATCH_COUNT)
  ) u_checker (
    .clk         (clk),
    .reset       (reset),
    .check_en    (check_en),
    .monitor_en  (monitor_en),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .miss        (miss),
    .match_done  (match_done),
    .miss_limit  (miss_limit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slip_d  = slip_count;
    unique case (state_q)
      StIdle, StFail: begin
        if (start) begin
          state_d = StRst;
          cnt_d   = '0;
          slip_d  = '0;
        end
      end
      StLocked: begin
        if (start) begin
          state_d = StRst;
          cnt_d   = '0;
          slip_d  = '0;
        end
`ifdef SYZYGY_ADC_ALIGN_MONITOR_EN
        else if (miss_limit) begin
          state_d = StRst;
          cnt_d   = '0;
          slip_d  = '0;
        end
`endif
      end
      StRst: begin
        if (cnt_q == CntW'(RST_CYCLES - 1)) begin
          state_d = StSettle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StSettle: begin
        if (cnt_q == CntW'(SETTLE_CYCLES - 1)) begin
          state_d = StCheck;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StCheck: begin
        if (match_done) begin
          state_d = StLocked;
        end else if (miss) begin
          // slip_count only advances below the limit, so it saturates.
          if (slip_count < 4'(MAX_SLIPS)) begin
            state_d = StSlip;
            slip_d  = slip_count + 4'd1;
          end else begin
            state_d = StFail;
          end
        end
      end
      StSlip: begin
        state_d = StSettle;
        cnt_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they align with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      slip_count   <= '0;
      serdes_reset <= 1'b1;
      bitslip      <= 1'b0;
      busy         <= 1'b0;
      locked       <= 1'b0;
      fail         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      slip_count   <= slip_d;
      serdes_reset <= (state_d == StRst);
      bitslip      <= (state_d == StSlip);
      busy         <= is_busy(state_d);
      locked       <= (state_d == StLocked);
      fail         <= (state_d == StFail);
    end
  end

endmodule
